// File: rtl/jstk_poll_ctrl_pkg.sv
// Shared definitions for the joystick poll controller: FSM encoding,
// command word layout and the bit positions of the received fields.
package jstk_poll_ctrl_pkg;

  // Controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_START = 3'd2,
    ST_XFER  = 3'd3,
    ST_LATCH = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  // Width of the poll-period counter and the POLL_DIV input.
  localparam int POLL_W = 16;

  // Command byte base; the low two bits carry the LED state.
  localparam logic [7:0] CMD_BASE = 8'h80;

  // One transfer moves this many bytes each way.
  localparam int BYTE_CNT = 5;
  localparam int WORD_W   = 8 * BYTE_CNT;

  // Field positions inside the 40-bit received word.
  localparam int X_LO_MSB = 39;
  localparam int X_LO_LSB = 32;
  localparam int X_HI_MSB = 25;
  localparam int X_HI_LSB = 24;
  localparam int Y_LO_MSB = 23;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_MSB = 9;
  localparam int Y_HI_LSB = 8;
  localparam int BTN_MSB  = 2;
  localparam int BTN_LSB  = 0;

  // Build the outgoing command word: command byte first, zero padding after.
  function automatic logic [WORD_W-1:0] led_cmd(input logic [1:0] led);
    return {CMD_BASE | {6'b0, led}, {(WORD_W - 8){1'b0}}};
  endfunction

endpackage

// File: rtl/poll_timer.sv
// Poll-period timer: emits a one-cycle tick every POLL_DIV enabled cycles.
// POLL_DIV is picked up whenever a period restarts; 0 behaves as 1.
module poll_timer
  import jstk_poll_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [POLL_W-1:0] POLL_DIV,
  output logic              TICK
);

  logic [POLL_W-1:0] r_cnt;
  logic [POLL_W-1:0] w_reload;
  logic              w_last;

  assign w_reload = (POLL_DIV == '0) ? POLL_W'(1) : POLL_DIV;
  assign w_last   = (r_cnt <= POLL_W'(1));
  assign TICK     = EN && w_last;

  // Down-counter: reload on reset and on the final count, freeze while disabled.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= w_reload;
    end else if (EN) begin
      r_cnt <= w_last ? w_reload : r_cnt - POLL_W'(1);
    end
  end

endmodule

// File: rtl/jstk_poll_ctrl.sv
// Joystick poll controller: periodically (or on an LED-update request)
// launches a 5-byte exchange through the SPI byte controller, decodes the
// returned position/button word and guards each transfer with a timeout.
module jstk_poll_ctrl
  import jstk_poll_ctrl_pkg::*;
#(
  parameter int TMO_CYC = 4096,
  parameter int GAP_CYC = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [POLL_W-1:0] POLL_DIV,
  input  logic              LED_REQ,
  input  logic [1:0]        LED_VAL,
  output logic              LED_ACK,
  input  logic              SS_MON,
  input  logic [WORD_W-1:0] DIN_RX,
  output logic              SND_REC,
  output logic [WORD_W-1:0] DIN_TX,
  output logic [9:0]        X_POS,
  output logic [9:0]        Y_POS,
  output logic [2:0]        BTN,
  output logic              SAMPLE_VLD,
  output logic              TIMEOUT
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 1) ? GAP_W'(GAP_CYC - 1) : '0;

  state_t            r_state;
  logic              r_poll_pend;
  logic              r_led_grant;
  logic [1:0]        r_led_val;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_snd_rec;
  logic [WORD_W-1:0] r_din_tx;
  logic [9:0]        r_x_pos;
  logic [9:0]        r_y_pos;
  logic [2:0]        r_btn;
  logic              r_sample_vld;
  logic              r_led_ack;
  logic              r_timeout;

  logic              w_tick;
  logic              w_tmo_hit;
  logic              w_unused_rx;

  // Received bits that carry no field; collected so they read as intentional.
  assign w_unused_rx = ^{DIN_RX[31:26], DIN_RX[15:10], DIN_RX[7:3]};

  assign w_tmo_hit = (r_tmo_cnt >= TMO_LAST);

  poll_timer u_poll_timer (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .POLL_DIV (POLL_DIV),
    .TICK     (w_tick)
  );

  // Transfer sequencer with all outputs registered; the pending-poll flag is
  // set by every tick and cleared only when an arbitration slot consumes it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_poll_pend  <= 1'b0;
      r_led_grant  <= 1'b0;
      r_led_val    <= 2'b00;
      r_tmo_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_snd_rec    <= 1'b0;
      r_din_tx     <= '0;
      r_x_pos      <= '0;
      r_y_pos      <= '0;
      r_btn        <= '0;
      r_sample_vld <= 1'b0;
      r_led_ack    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_sample_vld <= 1'b0;
      r_led_ack    <= 1'b0;
      if (w_tick) begin
        r_poll_pend <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (LED_REQ || r_poll_pend) begin
            r_state <= ST_ARB;
          end
        end

        ST_ARB: begin
          // One transfer always returns a sample, so it also serves any
          // pending poll; a tick landing in this very cycle stays pending.
          r_poll_pend <= w_tick;
          r_led_grant <= LED_REQ;
          if (LED_REQ) begin
            r_led_val <= LED_VAL;
            r_din_tx  <= led_cmd(LED_VAL);
          end else begin
            r_din_tx  <= led_cmd(r_led_val);
          end
          r_tmo_cnt <= '0;
          r_snd_rec <= 1'b1;
          r_state   <= ST_START;
        end

        ST_START: begin
          if (!SS_MON) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            r_state   <= ST_XFER;
          end else if (w_tmo_hit) begin
            r_snd_rec <= 1'b0;
            r_timeout <= 1'b1;
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end

        ST_XFER: begin
          if (SS_MON) begin
            r_snd_rec <= 1'b0;
            r_state   <= ST_LATCH;
          end else if (w_tmo_hit) begin
            r_snd_rec <= 1'b0;
            r_timeout <= 1'b1;
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end

        ST_LATCH: begin
          // Sampling one cycle after slave-select rises lets the byte
          // controller's last negedge update settle first.
          r_x_pos      <= {DIN_RX[X_HI_MSB:X_HI_LSB], DIN_RX[X_LO_MSB:X_LO_LSB]};
          r_y_pos      <= {DIN_RX[Y_HI_MSB:Y_HI_LSB], DIN_RX[Y_LO_MSB:Y_LO_LSB]};
          r_btn        <= DIN_RX[BTN_MSB:BTN_LSB];
          r_sample_vld <= 1'b1;
          r_led_ack    <= r_led_grant;
          r_gap_cnt    <= '0;
          r_state      <= ST_GAP;
        end

        ST_GAP: begin
          if (r_gap_cnt >= GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          r_snd_rec <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign SND_REC    = r_snd_rec;
  assign DIN_TX     = r_din_tx;
  assign X_POS      = r_x_pos;
  assign Y_POS      = r_y_pos;
  assign BTN        = r_btn;
  assign SAMPLE_VLD = r_sample_vld;
  assign LED_ACK    = r_led_ack;
  assign TIMEOUT    = r_timeout;

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Bench for jstk_poll_ctrl: a behavioural byte-controller model answers each
// transfer with a random word, and a monitor predicts the decoded fields,
// command word, LED acknowledgements and inter-transfer gaps.
module tb_jstk_poll_ctrl;

  localparam int TMO = 64;
  localparam int GAP = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [15:0] POLL_DIV;
  logic        LED_REQ;
  logic [1:0]  LED_VAL;
  logic        LED_ACK;
  logic        SS_MON;
  logic [39:0] DIN_RX;
  logic        SND_REC;
  logic [39:0] DIN_TX;
  logic [9:0]  X_POS;
  logic [9:0]  Y_POS;
  logic [2:0]  BTN;
  logic        SAMPLE_VLD;
  logic        TIMEOUT;

  jstk_poll_ctrl #(.TMO_CYC(TMO), .GAP_CYC(GAP)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .POLL_DIV   (POLL_DIV),
    .LED_REQ    (LED_REQ),
    .LED_VAL    (LED_VAL),
    .LED_ACK    (LED_ACK),
    .SS_MON     (SS_MON),
    .DIN_RX     (DIN_RX),
    .SND_REC    (SND_REC),
    .DIN_TX     (DIN_TX),
    .X_POS      (X_POS),
    .Y_POS      (Y_POS),
    .BTN        (BTN),
    .SAMPLE_VLD (SAMPLE_VLD),
    .TIMEOUT    (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- byte-controller model ----------------
  bit          model_hang = 1'b0;
  bit          first_word = 1'b1;
  logic [39:0] exp_q[$];
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [63:0] m_rand;

  initial begin
    SS_MON = 1'b1;
    DIN_RX = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        m_phase = 0;
        SS_MON  = 1'b1;
      end else begin
        case (m_phase)
          0: if (SND_REC && !model_hang) begin
               m_cnt   = $urandom_range(0, 2);
               m_phase = 1;
             end
          1: if (m_cnt == 0) begin
               SS_MON  = 1'b0;
               m_cnt   = $urandom_range(4, 12);
               m_phase = 2;
             end else m_cnt--;
          default: if (m_cnt == 0) begin
               m_rand = {$urandom, $urandom};
               DIN_RX = first_word ? 40'h2A01_F302_05 : m_rand[39:0];
               first_word = 1'b0;
               exp_q.push_back(DIN_RX);
               SS_MON  = 1'b1;
               m_phase = 0;
             end else m_cnt--;
        endcase
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  int              n_xfer = 0, n_samp = 0, n_ack = 0;
  int              zero_run = 0, high_run = 0, last_high = 0;
  bit              have_prev = 1'b0, cur_grant = 1'b0;
  logic [1:0]      m_led_reg = 2'b00;
  logic            prev_snd = 1'b0;
  longint unsigned wv, exp_x, exp_y, exp_b, exp_tx;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (RST) begin
        have_prev = 1'b0; zero_run = 0; high_run = 0;
        cur_grant = 1'b0; m_led_reg = 2'b00; prev_snd = 1'b0;
        exp_q.delete();
      end else begin
        if (SND_REC && !prev_snd) begin
          n_xfer++;
          if (have_prev) check("gap_min", (zero_run < GAP) ? zero_run : GAP, GAP);
          have_prev = 1'b1;
          zero_run  = 0;
          high_run  = 0;
          cur_grant = LED_REQ;
          if (LED_REQ) m_led_reg = LED_VAL;
          exp_tx = (longint'(128 + m_led_reg)) << 32;
          check("din_tx", DIN_TX, exp_tx);
        end
        if (SND_REC) high_run++;
        else begin
          if (prev_snd) last_high = high_run;
          zero_run++;
        end
        if (SAMPLE_VLD) begin
          n_samp++;
          if (exp_q.size() == 0) check("sample_unexpected", exp_q.size(), 1);
          else begin
            wv    = exp_q.pop_front();
            exp_x = ((wv >> 24) % 4) * 256 + ((wv >> 32) % 256);
            exp_y = ((wv >> 8) % 4) * 256 + ((wv >> 16) % 256);
            exp_b = wv % 8;
            check("x_pos", X_POS, exp_x);
            check("y_pos", Y_POS, exp_y);
            check("btn", BTN, exp_b);
          end
        end
        if (LED_ACK) n_ack++;
        if (LED_ACK || SAMPLE_VLD) check("led_ack", LED_ACK, SAMPLE_VLD && cur_grant);
        prev_snd = SND_REC;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_reset(input string tag);
    check({tag, "_snd_rec"}, SND_REC, 0);
    check({tag, "_din_tx"}, DIN_TX, 0);
    check({tag, "_x_pos"}, X_POS, 0);
    check({tag, "_y_pos"}, Y_POS, 0);
    check({tag, "_btn"}, BTN, 0);
    check({tag, "_sample_vld"}, SAMPLE_VLD, 0);
    check({tag, "_led_ack"}, LED_ACK, 0);
    check({tag, "_timeout"}, TIMEOUT, 0);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge CLK);
      #1;
      seen = LED_ACK;
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_timeout_flag(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge CLK);
      #1;
      seen = TIMEOUT;
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_ss_low(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge CLK);
      #1;
      seen = !SS_MON;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int  b_x, b_s, b_a;
  bit  first_seen;

  initial begin
    RST = 1'b1; EN = 1'b0; POLL_DIV = 16'd100; LED_REQ = 1'b0; LED_VAL = 2'b00;
    repeat (2) @(posedge CLK);
    #1;
    check_reset("por");

    // Periodic polling: 1050 enabled cycles at period 100 give 10 polls.
    @(negedge CLK);
    RST = 1'b0;
    EN  = 1'b1;
    b_x = n_xfer; b_s = n_samp; b_a = n_ack;
    first_seen = 1'b0;
    for (int i = 0; i < 1050; i++) begin
      @(posedge CLK);
      #1;
      if (SAMPLE_VLD && !first_seen) begin
        first_seen = 1'b1;
        check("first_x", X_POS, 10'h12A);
        check("first_y", Y_POS, 10'h2F3);
        check("first_btn", BTN, 3'b101);
      end
    end
    @(negedge CLK);
    EN = 1'b0;
    repeat (100) @(posedge CLK);
    #1;
    check("poll_first_seen", first_seen, 1);
    check("poll_samples", n_samp - b_s, 1050 / 100);
    check("poll_xfers", n_xfer - b_x, 1050 / 100);
    check("poll_acks", n_ack - b_a, 0);

    // LED updates back to back with polling disabled.
    b_x = n_xfer; b_s = n_samp; b_a = n_ack;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      LED_REQ = 1'b1;
      LED_VAL = (k == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      wait_ack("led_ack_wait", 200);
      if (k == 0) check("led11_cmd", DIN_TX[39:32], 8'h83);
    end
    @(negedge CLK);
    LED_REQ = 1'b0;
    repeat (100) @(posedge CLK);
    #1;
    check("led_xfers", n_xfer - b_x, 4);
    check("led_acks", n_ack - b_a, 4);
    check("led_samples", n_samp - b_s, 4);

    // LED request in the same cycle as the poll tick: one merged transfer.
    @(negedge CLK);
    POLL_DIV = 16'd50;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    EN  = 1'b1;
    b_x = n_xfer; b_s = n_samp; b_a = n_ack;
    repeat (49) @(negedge CLK);
    LED_REQ = 1'b1;
    LED_VAL = 2'($urandom_range(0, 3));
    @(negedge CLK);
    EN = 1'b0;
    wait_ack("merge_ack_wait", 200);
    @(negedge CLK);
    LED_REQ = 1'b0;
    repeat (150) @(posedge CLK);
    #1;
    check("merge_xfers", n_xfer - b_x, 1);
    check("merge_samples", n_samp - b_s, 1);
    check("merge_acks", n_ack - b_a, 1);

    // Unanswered transfer times out; the LED request is retried afterwards.
    b_x = n_xfer; b_s = n_samp; b_a = n_ack;
    model_hang = 1'b1;
    @(negedge CLK);
    LED_REQ = 1'b1;
    LED_VAL = 2'($urandom_range(0, 3));
    wait_timeout_flag("tmo_wait", 200);
    @(posedge CLK);
    #1;
    check("tmo_high_len", last_high, TMO);
    check("tmo_snd_rec", SND_REC, 0);
    check("tmo_samples", n_samp - b_s, 0);
    check("tmo_acks", n_ack - b_a, 0);
    @(negedge CLK);
    model_hang = 1'b0;
    wait_ack("retry_ack_wait", 200);
    @(negedge CLK);
    LED_REQ = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("retry_acks", n_ack - b_a, 1);
    check("retry_xfers", n_xfer - b_x, 2);
    check("retry_samples", n_samp - b_s, 1);
    check("tmo_sticky", TIMEOUT, 1);

    // Reset in the middle of a transfer, then a fresh poll.
    @(negedge CLK);
    POLL_DIV = 16'd20;
    LED_REQ  = 1'b1;
    LED_VAL  = 2'($urandom_range(0, 3));
    wait_ss_low("ss_low_wait", 100);
    @(negedge CLK);
    RST     = 1'b1;
    LED_REQ = 1'b0;
    @(posedge CLK);
    #1;
    check_reset("rst_xfer");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    EN  = 1'b1;
    b_x = n_xfer; b_s = n_samp; b_a = n_ack;
    repeat (30) @(negedge CLK);
    EN = 1'b0;
    repeat (80) @(posedge CLK);
    #1;
    check("post_rst_samples", n_samp - b_s, 30 / 20);
    check("post_rst_xfers", n_xfer - b_x, 30 / 20);
    check("post_rst_acks", n_ack - b_a, 0);
    check("post_rst_timeout", TIMEOUT, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
